// File: rtl/quantum_scheduler.sv
// Preemption and scheduling unit: counts user-mode cycles against per-process quanta, saves PCs,
// tracks blocked/finished slots and picks the next runnable process round-robin.
module quantum_scheduler #(
   parameter int unsigned PC_WIDTH        = 32,
   parameter int unsigned Q_WIDTH         = 16,
   parameter int unsigned NUM_PROCS       = 4,
   parameter int unsigned ID_WIDTH        = 2,
   parameter int unsigned DEFAULT_QUANTUM = 5,
   parameter int unsigned OS_PC_LIMIT     = 300
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [PC_WIDTH-1:0] pc,
   input  logic [ID_WIDTH-1:0] processoAtual,
   input  logic                InstrucaoIO,
   input  logic                fimProcesso,
   input  logic                io_done,
   input  logic [ID_WIDTH-1:0] io_done_proc,
   input  logic                cfg_we,
   input  logic [ID_WIDTH-1:0] cfg_proc,
   input  logic [Q_WIDTH-1:0]  cfg_quantum,
   input  logic                cfg_revive,
   input  logic [ID_WIDTH-1:0] rd_proc,
   output logic [PC_WIDTH-1:0] rd_pc,
   output logic                troca_contexto,
   output logic                intrucaoIOContexto,
   output logic [PC_WIDTH-1:0] pc_processo_trocado,
   output logic [ID_WIDTH-1:0] proc_trocado,
   output logic [ID_WIDTH-1:0] proximo_processo,
   output logic                proximo_valido
);

   localparam int Procs = int'(NUM_PROCS);
   localparam logic [PC_WIDTH-1:0] OsLimit    = PC_WIDTH'(OS_PC_LIMIT);
   localparam logic [Q_WIDTH-1:0]  DefQuantum = Q_WIDTH'(DEFAULT_QUANTUM);

   typedef enum logic [1:0] {StOs, StRun, StSwitch} state_e;

   state_e               state_q, state_d;
   logic [Q_WIDTH-1:0]   counter_q, counter_d;
   logic [Q_WIDTH-1:0]   quantum_q [NUM_PROCS];
   logic [Q_WIDTH-1:0]   quantum_d [NUM_PROCS];
   logic [PC_WIDTH-1:0]  saved_pc_q [NUM_PROCS];
   logic [PC_WIDTH-1:0]  saved_pc_d [NUM_PROCS];
   logic [NUM_PROCS-1:0] blocked_q, blocked_d, finished_q, finished_d;

   logic                 troca_q, troca_d;
   logic                 io_ctx_q, io_ctx_d;
   logic [PC_WIDTH-1:0]  pc_trocado_q, pc_trocado_d;
   logic [ID_WIDTH-1:0]  proc_trocado_q, proc_trocado_d;
   logic [ID_WIDTH-1:0]  proximo_q, proximo_d;
   logic                 valido_q, valido_d;

   logic                 in_run;
   logic                 take_event;
   logic [PC_WIDTH-1:0]  pc_next;
   logic [ID_WIDTH-1:0]  cand;
   logic [ID_WIDTH-1:0]  pick_id;
   logic                 pick_valid;

   assign in_run  = (state_q != StSwitch) && (pc > OsLimit);
   assign pc_next = pc + 1'b1;

   always_comb begin
      state_d        = state_q;
      counter_d      = counter_q;
      quantum_d      = quantum_q;
      saved_pc_d     = saved_pc_q;
      blocked_d      = blocked_q;
      finished_d     = finished_q;
      troca_d        = 1'b0;
      io_ctx_d       = 1'b0;
      pc_trocado_d   = pc_trocado_q;
      proc_trocado_d = proc_trocado_q;
      proximo_d      = proximo_q;
      valido_d       = valido_q;
      take_event     = 1'b0;
      cand           = '0;
      pick_id        = '0;
      pick_valid     = 1'b0;

      // Wake and config first so a same-edge I/O block still wins.
      if (io_done) blocked_d[io_done_proc] = 1'b0;
      if (cfg_we) begin
         quantum_d[cfg_proc] = cfg_quantum;
         if (cfg_revive) begin
            blocked_d[cfg_proc]  = 1'b0;
            finished_d[cfg_proc] = 1'b0;
         end
      end

      if (in_run) begin
         if (fimProcesso) begin
            finished_d[processoAtual] = 1'b1;
            counter_d      = '0;
            troca_d        = 1'b1;
            proc_trocado_d = processoAtual;
            take_event     = 1'b1;
         end else if (counter_q >= quantum_q[processoAtual]) begin
            saved_pc_d[processoAtual] = pc_next;
            pc_trocado_d   = pc_next;
            counter_d      = '0;
            troca_d        = 1'b1;
            proc_trocado_d = processoAtual;
            take_event     = 1'b1;
         end else if (InstrucaoIO) begin
            saved_pc_d[processoAtual] = pc_next;
            blocked_d[processoAtual]  = 1'b1;
            pc_trocado_d   = pc_next;
            counter_d      = '0;
            io_ctx_d       = 1'b1;
            proc_trocado_d = processoAtual;
            take_event     = 1'b1;
         end else if (counter_q != '1) begin
            counter_d = counter_q + 1'b1;
         end
      end

      // Scan from the farthest offset down so the nearest runnable id wins.
      for (int k = Procs; k > 0; k--) begin
         cand = processoAtual + ID_WIDTH'(k);
         if (!blocked_d[cand] && !finished_d[cand]) begin
            pick_id    = cand;
            pick_valid = 1'b1;
         end
      end

      if (take_event) begin
         proximo_d = pick_id;
         valido_d  = pick_valid;
         state_d   = StSwitch;
      end else begin
         state_d = (pc > OsLimit) ? StRun : StOs;
      end
   end

   always_ff @(negedge clock or negedge reset) begin
      if (!reset) begin
         state_q        <= StOs;
         counter_q      <= '0;
         blocked_q      <= '0;
         finished_q     <= '0;
         for (int i = 0; i < Procs; i++) begin
            quantum_q[i]  <= DefQuantum;
            saved_pc_q[i] <= '0;
         end
         troca_q        <= 1'b0;
         io_ctx_q       <= 1'b0;
         pc_trocado_q   <= '0;
         proc_trocado_q <= '0;
         proximo_q      <= '0;
         valido_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         counter_q      <= counter_d;
         blocked_q      <= blocked_d;
         finished_q     <= finished_d;
         quantum_q      <= quantum_d;
         saved_pc_q     <= saved_pc_d;
         troca_q        <= troca_d;
         io_ctx_q       <= io_ctx_d;
         pc_trocado_q   <= pc_trocado_d;
         proc_trocado_q <= proc_trocado_d;
         proximo_q      <= proximo_d;
         valido_q       <= valido_d;
      end
   end

   assign rd_pc               = saved_pc_q[rd_proc];
   assign troca_contexto      = troca_q;
   assign intrucaoIOContexto  = io_ctx_q;
   assign pc_processo_trocado = pc_trocado_q;
   assign proc_trocado        = proc_trocado_q;
   assign proximo_processo    = proximo_q;
   assign proximo_valido      = valido_q;

endmodule

// File: tb/tb_quantum_scheduler.sv
// Directed bench for quantum_scheduler: vector table for expiry and I/O block, hand sequences
// for wake, process end, OS exclusion, priority/collision and asynchronous reset.
module tb_quantum_scheduler;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic [1:0]  processoAtual;
   logic        InstrucaoIO;
   logic        fimProcesso;
   logic        io_done;
   logic [1:0]  io_done_proc;
   logic        cfg_we;
   logic [1:0]  cfg_proc;
   logic [15:0] cfg_quantum;
   logic        cfg_revive;
   logic [1:0]  rd_proc;
   logic [31:0] rd_pc;
   logic        troca_contexto;
   logic        intrucaoIOContexto;
   logic [31:0] pc_processo_trocado;
   logic [1:0]  proc_trocado;
   logic [1:0]  proximo_processo;
   logic        proximo_valido;

   int n_tests = 0;
   int n_fail  = 0;

   quantum_scheduler dut (
      .clock               (clock),
      .reset               (reset),
      .pc                  (pc),
      .processoAtual       (processoAtual),
      .InstrucaoIO         (InstrucaoIO),
      .fimProcesso         (fimProcesso),
      .io_done             (io_done),
      .io_done_proc        (io_done_proc),
      .cfg_we              (cfg_we),
      .cfg_proc            (cfg_proc),
      .cfg_quantum         (cfg_quantum),
      .cfg_revive          (cfg_revive),
      .rd_proc             (rd_proc),
      .rd_pc               (rd_pc),
      .troca_contexto      (troca_contexto),
      .intrucaoIOContexto  (intrucaoIOContexto),
      .pc_processo_trocado (pc_processo_trocado),
      .proc_trocado        (proc_trocado),
      .proximo_processo    (proximo_processo),
      .proximo_valido      (proximo_valido)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] pc;
      logic [1:0]  proc;
      logic        io;
      logic        troca;
      logic        ioctx;
      logic [31:0] pctr;
      logic [1:0]  prox;
      logic        valid;
   } vec_t;

   vec_t vecs [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Falling edge updates state; sample 1 time unit later.
   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   task automatic os_tick();
      pc = 32'd300; InstrucaoIO = 1'b0; fimProcesso = 1'b0;
      tick();
   endtask

   task automatic cfg_write(input logic [1:0] p, input logic [15:0] q, input logic rev);
      cfg_we = 1'b1; cfg_proc = p; cfg_quantum = q; cfg_revive = rev;
      os_tick();
      cfg_we = 1'b0; cfg_revive = 1'b0;
   endtask

   task automatic run(input logic [1:0] p, input logic [31:0] a, input logic io, input logic fim);
      processoAtual = p; pc = a; InstrucaoIO = io; fimProcesso = fim;
      tick();
      InstrucaoIO = 1'b0; fimProcesso = 1'b0;
   endtask

   initial begin
      reset = 1'b0; pc = 32'd300; processoAtual = '0; InstrucaoIO = 0; fimProcesso = 0;
      io_done = 0; io_done_proc = '0; cfg_we = 0; cfg_proc = '0; cfg_quantum = '0;
      cfg_revive = 0; rd_proc = '0;

      for (int i = 0; i < 6; i++) vecs[i] = '{32'd301 + i, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0};
      vecs[5]  = '{32'd306, 2'd0, 1'b0, 1'b1, 1'b0, 32'd307, 2'd1, 1'b1};
      for (int i = 6; i < 12; i++) vecs[i] = '{32'd301 + i, 2'd0, 1'b0, 1'b0, 1'b0, 32'd307, 2'd1, 1'b1};
      vecs[12] = '{32'd313, 2'd0, 1'b0, 1'b1, 1'b0, 32'd314, 2'd1, 1'b1};
      vecs[13] = '{32'd314, 2'd0, 1'b0, 1'b0, 1'b0, 32'd314, 2'd1, 1'b1};
      vecs[14] = '{32'd400, 2'd2, 1'b1, 1'b0, 1'b1, 32'd401, 2'd3, 1'b1};
      vecs[15] = '{32'd401, 2'd2, 1'b1, 1'b0, 1'b0, 32'd401, 2'd3, 1'b1};

      tick();
      check("reset troca", troca_contexto, 0);
      check("reset ioctx", intrucaoIOContexto, 0);
      check("reset pctr", pc_processo_trocado, 0);
      check("reset proc_trocado", proc_trocado, 0);
      check("reset proximo", proximo_processo, 0);
      check("reset valido", proximo_valido, 0);
      check("reset rd_pc", rd_pc, 0);
      tick();
      reset = 1'b1;

      // Quantum expiry, counter restart and I/O block
      cfg_write(2'd0, 16'd5, 1'b0);
      for (int i = 0; i < 16; i++) begin
         run(vecs[i].proc, vecs[i].pc, vecs[i].io, 1'b0);
         check($sformatf("vec%0d troca", i), troca_contexto, vecs[i].troca);
         check($sformatf("vec%0d ioctx", i), intrucaoIOContexto, vecs[i].ioctx);
         check($sformatf("vec%0d pctr", i), pc_processo_trocado, vecs[i].pctr);
         check($sformatf("vec%0d prox", i), proximo_processo, vecs[i].prox);
         check($sformatf("vec%0d valid", i), proximo_valido, vecs[i].valid);
      end
      check("vec proc_trocado", proc_trocado, 2);
      rd_proc = 2'd2; #1 check("rd_pc slot2", rd_pc, 401);
      rd_proc = 2'd0; #1 check("rd_pc slot0", rd_pc, 314);

      // Blocked slot skipped until io_done; q=0 switches on first RUN cycle
      cfg_write(2'd1, 16'd0, 1'b0);
      run(2'd1, 32'd500, 1'b0, 1'b0);
      check("q0 troca", troca_contexto, 1);
      check("skip blocked prox", proximo_processo, 3);
      check("q0 pctr", pc_processo_trocado, 501);
      os_tick();
      io_done = 1'b1; io_done_proc = 2'd2;
      os_tick();
      io_done = 1'b0;
      run(2'd1, 32'd510, 1'b0, 1'b0);
      check("woken prox", proximo_processo, 2);
      check("woken valid", proximo_valido, 1);
      os_tick();

      // Process end and empty set, then revive
      run(2'd0, 32'd600, 1'b0, 1'b1);
      check("fim0 troca", troca_contexto, 1);
      check("fim0 proc_trocado", proc_trocado, 0);
      check("fim0 prox", proximo_processo, 1);
      check("fim0 pctr kept", pc_processo_trocado, 511);
      os_tick();
      run(2'd1, 32'd610, 1'b0, 1'b1);
      check("fim1 prox", proximo_processo, 2);
      os_tick();
      run(2'd2, 32'd620, 1'b0, 1'b1);
      check("fim2 prox", proximo_processo, 3);
      os_tick();
      run(2'd3, 32'd700, 1'b1, 1'b0);
      check("io3 ioctx", intrucaoIOContexto, 1);
      check("io3 troca", troca_contexto, 0);
      check("empty valid", proximo_valido, 0);
      check("io3 pctr", pc_processo_trocado, 701);
      os_tick();
      cfg_write(2'd1, 16'd5, 1'b1);
      run(2'd0, 32'd800, 1'b0, 1'b1);
      check("revive prox", proximo_processo, 1);
      check("revive valid", proximo_valido, 1);

      // OS exclusion: 20 cycles at the limit, then q+1 counted cycles
      processoAtual = 2'd1;
      for (int i = 0; i < 20; i++) begin
         os_tick();
         check($sformatf("os%0d troca", i), troca_contexto, 0);
      end
      for (int i = 0; i < 6; i++) begin
         run(2'd1, 32'd301 + i, 1'b0, 1'b0);
         check($sformatf("osx%0d troca", i), troca_contexto, (i == 5));
      end
      check("osx pctr", pc_processo_trocado, 307);
      check("osx proc_trocado", proc_trocado, 1);
      check("osx prox", proximo_processo, 1);
      os_tick();

      // Priority: end beats expiry and I/O; no PC save
      cfg_write(2'd1, 16'd0, 1'b0);
      run(2'd1, 32'd900, 1'b1, 1'b1);
      check("prio troca", troca_contexto, 1);
      check("prio ioctx", intrucaoIOContexto, 0);
      check("prio pctr", pc_processo_trocado, 307);
      check("prio valid", proximo_valido, 0);
      rd_proc = 2'd1; #1 check("prio rd_pc", rd_pc, 307);
      os_tick();

      // Collision: same-edge io_done loses to the block
      cfg_write(2'd2, 16'd5, 1'b1);
      io_done = 1'b1; io_done_proc = 2'd2;
      run(2'd2, 32'd910, 1'b1, 1'b0);
      io_done = 1'b0;
      check("coll ioctx", intrucaoIOContexto, 1);
      check("coll pctr", pc_processo_trocado, 911);
      check("coll still blocked", proximo_valido, 0);
      os_tick();

      // Asynchronous reset mid-pulse
      cfg_write(2'd0, 16'd0, 1'b1);
      run(2'd0, 32'd1000, 1'b0, 1'b0);
      check("pre-reset troca", troca_contexto, 1);
      #2 reset = 1'b0;
      rd_proc = 2'd0;
      #1;
      check("rst troca", troca_contexto, 0);
      check("rst ioctx", intrucaoIOContexto, 0);
      check("rst pctr", pc_processo_trocado, 0);
      check("rst proc_trocado", proc_trocado, 0);
      check("rst prox", proximo_processo, 0);
      check("rst valid", proximo_valido, 0);
      check("rst rd_pc", rd_pc, 0);
      os_tick();
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         run(2'd0, 32'd301 + i, 1'b0, 1'b0);
         check($sformatf("rstq%0d troca", i), troca_contexto, (i == 5));
      end
      check("rstq pctr", pc_processo_trocado, 307);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
